// File: rtl/ftdi_sync_tx.sv
// Byte stream to FT232H synchronous FIFO write port: small elastic FIFO,
// registered WR#/data holding stage and a send-immediate (SIWU#) generator.
module ftdi_sync_tx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SIWU_IDLE  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sink_stb,
   output logic       sink_ack,
   input  logic [7:0] sink_d,
   input  logic       sink_last,
   input  logic       ftdi_txe_n,
   output logic       ftdi_wr_n,
   output logic [7:0] ftdi_d,
   output logic       ftdi_siwu_n
);

   localparam int unsigned  AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned  PW      = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [7:0]   CNT_TOP = 8'(SIWU_IDLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRE  = 2'd2
   } siwu_state_t;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [8:0]    head;
   logic          running;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          xfer;
   logic          idle;

   logic          out_valid;
   logic          out_last;
   logic [7:0]    out_d;

   siwu_state_t   state;
   siwu_state_t   state_next;
   logic [7:0]    cnt;
   logic [7:0]    cnt_next;
   logic          siwu_n_next;

   // running gates sink_ack so it stays low through reset and rises on the
   // first edge after, without any combinational path from rst.
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty    = (wr_ptr == rd_ptr);
   assign sink_ack = running && !full;
   assign push     = sink_stb && sink_ack;
   assign xfer     = out_valid && !ftdi_txe_n;
   assign pop      = !empty && (!out_valid || xfer);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign idle     = !out_valid && empty;

   assign ftdi_d    = out_d;
   assign ftdi_wr_n = !out_valid;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {sink_last, sink_d};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         running <= 1'b0;
      end else begin
         running <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_d     <= '0;
         out_last  <= 1'b0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_d     <= head[7:0];
         out_last  <= head[8];
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ftdi_siwu_n <= 1'b1;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         ftdi_siwu_n <= siwu_n_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (xfer && out_last) begin
               state_next = ARMED;
               cnt_next   = '0;
            end
         end
         ARMED: begin
            if (xfer && out_last) begin
               cnt_next = '0;
            end else if (idle) begin
               if (cnt == CNT_TOP) begin
                  state_next = FIRE;
               end else if (cnt != '1) begin
                  cnt_next = cnt + 8'd1;
               end
            end else begin
               cnt_next = '0;
            end
         end
         FIRE: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // SIWU# is registered from the next state, so it is low exactly while in FIRE.
   always_comb begin
      siwu_n_next = (state_next != FIRE);
   end

endmodule

// File: tb/tb_ftdi_sync_tx.sv
// Directed and randomised checks of ftdi_sync_tx ordering, latency, flow
// control, SIWU# timing and reset behaviour.
module tb_ftdi_sync_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       sink_stb;
   logic       sink_ack;
   logic [7:0] sink_d;
   logic       sink_last;
   logic       ftdi_txe_n;
   logic       ftdi_wr_n;
   logic [7:0] ftdi_d;
   logic       ftdi_siwu_n;

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   int          n_acc = 0;
   int          n_xfer = 0;
   int          n_siwu = 0;
   int          siwu_edge = 0;
   bit          rand_mode = 1'b0;
   logic [8:0]  mon_head;
   logic [8:0]  exp_q [$];
   int          xlog_d [$];
   int          xlog_e [$];
   int          alog_e [$];

   ftdi_sync_tx #(
      .FIFO_DEPTH(4),
      .SIWU_IDLE (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sink_stb   (sink_stb),
      .sink_ack   (sink_ack),
      .sink_d     (sink_d),
      .sink_last  (sink_last),
      .ftdi_txe_n (ftdi_txe_n),
      .ftdi_wr_n  (ftdi_wr_n),
      .ftdi_d     (ftdi_d),
      .ftdi_siwu_n(ftdi_siwu_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Edge numbers: an event logged at a falling edge happens on edge cyc+1.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (ftdi_wr_n === 1'b0 && ftdi_txe_n === 1'b0) begin
            n_xfer++;
            xlog_d.push_back(int'(ftdi_d));
            xlog_e.push_back(int'(cyc) + 1);
            if (exp_q.size() == 0) begin
               check("xfer_spurious", 32'(exp_q.size()), 32'd1);
            end else begin
               mon_head = exp_q.pop_front();
               check("xfer_data", 32'(ftdi_d), 32'(mon_head[7:0]));
            end
         end
         if (sink_stb === 1'b1 && sink_ack === 1'b1) begin
            n_acc++;
            alog_e.push_back(int'(cyc) + 1);
            exp_q.push_back({sink_last, sink_d});
         end
      end
      if (ftdi_siwu_n === 1'b0) begin
         n_siwu++;
         siwu_edge = int'(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      xlog_d.delete();
      xlog_e.delete();
      alog_e.delete();
      n_siwu = 0;
      n_acc  = 0;
      n_xfer = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      logic acc;
      int   waited;
      acc    = 1'b0;
      waited = 0;
      sink_stb  = 1'b1;
      sink_d    = d;
      sink_last = l;
      while (!acc && waited < 200) begin
         @(negedge clk);
         acc = sink_ack;
         @(posedge clk);
         #1;
         waited++;
         if (rand_mode) ftdi_txe_n = 1'($urandom_range(0, 1));
      end
      sink_stb = 1'b0;
      check("send_accept", 32'(acc), 32'd1);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: time limit reached before the end of the run");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      sink_stb   = 1'b0;
      sink_d     = 8'h00;
      sink_last  = 1'b0;
      ftdi_txe_n = 1'b1;

      // Reset state
      step(3);
      check("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
      check("rst_d", 32'(ftdi_d), 32'h00);
      check("rst_siwu_n", 32'(ftdi_siwu_n), 32'd1);
      check("rst_ack", 32'(sink_ack), 32'd0);
      rst = 1'b0;
      step(1);
      check("ack_after_rst", 32'(sink_ack), 32'd1);
      check("wr_n_after_rst", 32'(ftdi_wr_n), 32'd1);

      // Push into an empty block: no same-edge bypass, WR# one edge later
      clear_logs();
      send_byte(8'h21, 1'b0);
      check("no_bypass_wr_n", 32'(ftdi_wr_n), 32'd1);
      step(1);
      check("lat_wr_n", 32'(ftdi_wr_n), 32'd0);
      check("lat_d", 32'(ftdi_d), 32'h21);
      ftdi_txe_n = 1'b0;
      step(3);
      check("lat_xfer_cnt", 32'(xlog_d.size()), 32'd1);

      // Streaming packet 0x01..0x08 with TXE# low
      clear_logs();
      for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8));
      step(25);
      check("t1_count", 32'(xlog_d.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < xlog_d.size()) begin
            check("t1_byte", 32'(xlog_d[i]), 32'(i + 1));
            check("t1_consec", 32'(xlog_e[i] - xlog_e[0]), 32'(i));
         end
      end
      if (xlog_e.size() > 0 && alog_e.size() > 0)
         check("t1_latency", 32'(xlog_e[0] - alog_e[0]), 32'd2);
      check("t1_siwu_cnt", 32'(n_siwu), 32'd1);
      if (xlog_e.size() == 8)
         check("t1_siwu_dly", 32'(siwu_edge - xlog_e[7]), 32'd16);

      // Back-pressure: 4 in FIFO + 1 held, then release
      clear_logs();
      ftdi_txe_n = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b0);
      check("t2_ack4", 32'(sink_ack), 32'd1);
      send_byte(8'h15, 1'b0);
      check("t2_ack5", 32'(sink_ack), 32'd0);
      check("t2_hold_d", 32'(ftdi_d), 32'h11);
      check("t2_wr_n", 32'(ftdi_wr_n), 32'd0);
      sink_stb  = 1'b1;
      sink_d    = 8'h16;
      sink_last = 1'b1;
      step(3);
      check("t2_held_d", 32'(ftdi_d), 32'h11);
      check("t2_ack_full", 32'(sink_ack), 32'd0);
      check("t2_no_xfer", 32'(xlog_d.size()), 32'd0);
      check("t2_acc5", 32'(n_acc), 32'd5);
      ftdi_txe_n = 1'b0;
      check("t2_ack_pop_cycle", 32'(sink_ack), 32'd0);
      step(1);
      check("t2_ack_rise", 32'(sink_ack), 32'd1);
      check("t2_acc_nopush", 32'(n_acc), 32'd5);
      check("t2_xfer1", 32'(xlog_d.size()), 32'd1);
      step(1);
      sink_stb = 1'b0;
      check("t2_acc6", 32'(n_acc), 32'd6);
      check("t2_ack_steady", 32'(sink_ack), 32'd1);
      step(30);
      check("t2_total", 32'(xlog_d.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < xlog_d.size()) check("t2_order", 32'(xlog_d[i]), 32'(8'h11 + i));

      // Two packets close together: one SIWU pulse, timed from B's end
      clear_logs();
      send_byte(8'h31, 1'b0);
      send_byte(8'h32, 1'b0);
      send_byte(8'h33, 1'b1);
      step(6);
      send_byte(8'h41, 1'b0);
      send_byte(8'h42, 1'b0);
      send_byte(8'h43, 1'b1);
      step(30);
      check("t3_count", 32'(xlog_d.size()), 32'd6);
      check("t3_siwu_cnt", 32'(n_siwu), 32'd1);
      if (xlog_e.size() == 6)
         check("t3_siwu_dly", 32'(siwu_edge - xlog_e[5]), 32'd16);

      // Reset with bytes queued and data offered during reset
      clear_logs();
      ftdi_txe_n = 1'b1;
      send_byte(8'h51, 1'b0);
      send_byte(8'h52, 1'b0);
      send_byte(8'h53, 1'b1);
      rst       = 1'b1;
      sink_stb  = 1'b1;
      sink_d    = 8'h5F;
      sink_last = 1'b1;
      step(1);
      rst      = 1'b0;
      sink_stb = 1'b0;
      check("t4_wr_n_rst", 32'(ftdi_wr_n), 32'd1);
      check("t4_siwu_rst", 32'(ftdi_siwu_n), 32'd1);
      step(1);
      check("t4_ack", 32'(sink_ack), 32'd1);
      check("t4_wr_n", 32'(ftdi_wr_n), 32'd1);
      check("t4_siwu_n", 32'(ftdi_siwu_n), 32'd1);
      ftdi_txe_n = 1'b0;
      step(10);
      check("t4_no_stale", 32'(xlog_d.size()), 32'd0);
      send_byte(8'h61, 1'b0);
      step(25);
      check("t4_fresh_count", 32'(xlog_d.size()), 32'd1);
      if (xlog_d.size() > 0) check("t4_fresh_d", 32'(xlog_d[0]), 32'h61);
      check("t4_no_siwu", 32'(n_siwu), 32'd0);

      // 1000 random bytes with TXE# toggling randomly
      clear_logs();
      rand_mode = 1'b1;
      repeat (1000) begin
         repeat ($urandom_range(0, 2)) begin
            step(1);
            ftdi_txe_n = 1'($urandom_range(0, 1));
         end
         send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
      end
      rand_mode  = 1'b0;
      ftdi_txe_n = 1'b0;
      step(30);
      check("t5_acc", 32'(n_acc), 32'd1000);
      check("t5_xfer_eq_acc", 32'(n_xfer), 32'(n_acc));
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
